reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
Parametrised successor to the triplicated power-on/external reset combiner. It merges the external async reset and a power-on request, synchronises the release, and stretches reset for a fixed number of cycles. It then releases NCH reset domains in a fixed order, GAP cycles apart, and accepts a synchronous software reset request. It sits at the top of each clock domain; tmrg triplicates it.

Parameters:
NCH, 3, number of sequenced reset outputs (1..16)
SYNC_STAGES, 2, synchroniser depth for reset release (2..4)
STRETCH, 16, cycles reset is held after synchronised release (1..65535)
GAP, 4, cycles between consecutive channel releases (1..255)

Ports:
clk  input  1  single clock for the whole block
rstn  input  1  reset, asynchronous, active-low
por  input  1  power-on reset request, asynchronous, active-high; ORed with !rstn
sw_rst_req  input  1  synchronous software reset request, active-high, sampled on clk
rst  output  NCH  per-domain reset, active-high; bit 0 released first
ready  output  1  high when all domains are out of reset
busy  output  1  high while in SYNC, STRETCH or RELEASE

Behaviour:
- raw_rst = !rstn | por. Assertion is asynchronous: all flops clear immediately, rst = all ones, ready = 0, busy = 0, state = RESET.
- Reset values: rst = {NCH{1}}, ready = 0, busy = 0, counters = 0.
- Release path:
  - A SYNC_STAGES-deep chain is async-cleared by raw_rst and shifts in 1 after release.
  - State moves RESET -> SYNC on the first edge after release. busy = 1 from then on.
- States and transitions:
  - RESET: left when raw_rst is low.
  - SYNC: waits for the chain output, then STRETCH with cnt = 0.
  - STRETCH: counts STRETCH cycles, then RELEASE with ch = 0.
  - RELEASE: clears rst[ch] and waits GAP cycles before clearing rst[ch+1].
  - RUN: entered after rst[NCH-1] clears.
- Timing, counted from rstn rising with por low:
  - rst[0] falls at rising edge SYNC_STAGES+STRETCH.
  - rst[k] falls at edge SYNC_STAGES+STRETCH+k*GAP.
  - ready rises and busy falls on the same edge as rst[NCH-1].
- rst bits only ever change 1->0 one at a time in channel order, or all to 1 together. No glitches: every rst bit is a flop output.
- sw_rst_req in RUN:
  - On the next edge, rst = all ones, ready = 0, busy = 1, state = STRETCH, cnt = 0.
  - The synchroniser is skipped; rst[0] falls STRETCH edges after that edge.
- sw_rst_req in STRETCH or RELEASE: restarts STRETCH from cnt = 0 and re-asserts every released channel on the next edge.
- sw_rst_req in RESET or SYNC: ignored.
- sw_rst_req held high: re-triggers every cycle, so reset stays asserted and busy stays high.
- raw_rst asserted mid-sequence, in any state: immediate async return to RESET with all rst high. The full sequence, including sync, restarts on release.
- por glitch shorter than a clock period still fully resets the block, because assertion is async.
- Counter widths are derived from STRETCH and GAP with $clog2. Counters do not wrap: they saturate at terminal count and are reloaded on state entry.
- NCH = 1: RELEASE lasts one cycle, and ready rises with rst[0].

Decomposition:
- Shared package rst_seq_pkg holds:
  - state enum {RESET, SYNC, STRETCH, RELEASE, RUN}
  - width helper functions for the counter and channel index
  - limit constants for parameter range checks
- One sub-module: reset_sync (async-assert, sync-release chain, parametrised by SYNC_STAGES). It is reused elsewhere for plain reset synchronisation.
- All other logic stays in reset_sequencer.

Test Plan:
1. Defaults, rstn low 5 cycles then high, por low -> rst = 3'b111 until edge 18; rst[0] falls at edge 18, rst[1] at 22, rst[2] at 26; ready rises and busy falls at edge 26.
2. In RUN, pulse sw_rst_req one cycle at edge E -> rst = 3'b111 and ready = 0 after E; rst[0] falls at E+16, rst[1] at E+20, rst[2] at E+24; ready rises at E+24.
3. sw_rst_req during RELEASE, after rst[0] released and before rst[1] -> rst[0] re-asserts next edge; STRETCH restarts; release order repeats with full 16 + 4 + 4 timing.
4. por pulse of 3 ns mid-clock while in RUN -> rst = 3'b111 and ready = 0 immediately (async); sequence completes 26 edges after por falls.
5. rstn dropped during STRETCH at cnt = 7 -> immediate full reset; after release, rst[0] falls exactly at edge 18 (no carry-over of cnt).
6. Parameter sweep NCH = 1, SYNC_STAGES = 3, STRETCH = 1, GAP = 1 -> rst[0] and ready change at edge 4; sw_rst_req held high 10 cycles keeps rst = 1 and busy = 1 throughout, then rst[0] falls one edge after release.

Source files
------------

// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_pkg
// Description : Shared state encodings, counter width helpers and parameter
//               range limits for the reset sequencer and its synchroniser.
// Revision    : 1.0 - initial release
// ============================================================================
package rst_seq_pkg;

    // Parameter range limits checked at elaboration
    localparam int C_NCH_MIN     = 1;
    localparam int C_NCH_MAX     = 16;
    localparam int C_SYNC_MIN    = 2;
    localparam int C_SYNC_MAX    = 4;
    localparam int C_STRETCH_MIN = 1;
    localparam int C_STRETCH_MAX = 65535;
    localparam int C_GAP_MIN     = 1;
    localparam int C_GAP_MAX     = 255;

    // Sequencer states
    typedef logic [2:0] state_t;
    localparam state_t ST_RESET   = 3'd0;
    localparam state_t ST_SYNC    = 3'd1;
    localparam state_t ST_STRETCH = 3'd2;
    localparam state_t ST_RELEASE = 3'd3;
    localparam state_t ST_RUN     = 3'd4;

    // Bits needed for a counter running 0 .. terminal-1 (never below 1)
    function automatic int cnt_width(input int terminal);
        return (terminal <= 1) ? 1 : $clog2(terminal);
    endfunction

    // Bits needed to index n channels
    function automatic int idx_width(input int n);
        return cnt_width(n);
    endfunction

endpackage : rst_seq_pkg
`default_nettype wire

// File: rtl/reset_sync.sv
`default_nettype none
// ============================================================================
// Module      : reset_sync
// Description : Asynchronous-assert, synchronous-release reset chain. The
//               chain clears immediately on arst_n low and shifts in ones
//               after release. rel_early_n is the stage feeding the output,
//               i.e. it announces release one cycle ahead of rel_n.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sync
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic arst_n,
    output logic rel_n,
    output logic rel_early_n
);

    if (SYNC_STAGES < C_SYNC_MIN || SYNC_STAGES > C_SYNC_MAX) begin : g_param_check
        $error("reset_sync: SYNC_STAGES out of range");
    end

    logic [SYNC_STAGES-1:0] r_chain;

    // Shift ones into the chain once the asynchronous reset is released
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rel_n       = r_chain[SYNC_STAGES-1];
    assign rel_early_n = r_chain[SYNC_STAGES-2];

endmodule : reset_sync
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Combines external reset and power-on request, synchronises
//               the release, stretches reset, then releases NCH domains in
//               order GAP cycles apart. A synchronous software request
//               restarts the stretch phase without re-synchronising.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NCH         = 3,
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH     = 16,
    parameter int GAP         = 4
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           por,
    input  logic           sw_rst_req,
    output logic [NCH-1:0] rst,
    output logic           ready,
    output logic           busy
);

    if (NCH < C_NCH_MIN || NCH > C_NCH_MAX ||
        STRETCH < C_STRETCH_MIN || STRETCH > C_STRETCH_MAX ||
        GAP < C_GAP_MIN || GAP > C_GAP_MAX) begin : g_param_check
        $error("reset_sequencer: parameter out of range");
    end

    localparam int CNT_W = cnt_width(STRETCH);
    localparam int GAP_W = cnt_width(GAP);
    localparam int CH_W  = idx_width(NCH);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STRETCH - 1);
    localparam logic [GAP_W-1:0] C_GAP_LAST = GAP_W'(GAP - 1);
    localparam logic [CH_W-1:0]  C_CH_LAST  = CH_W'(NCH - 1);
    localparam logic [NCH-1:0]   C_CH_ONE   = NCH'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [GAP_W-1:0] r_gcnt;
    logic [CH_W-1:0]  r_ch;
    logic [NCH-1:0]   r_rst;
    logic             r_ready;
    logic             r_busy;

    logic             w_arst_n;
    logic             w_rel;
    logic             w_rel_early;
    logic [CH_W-1:0]  w_ch_next;
    logic             w_sw_restart;

    // Either source asserts reset; assertion reaches every flop asynchronously
    assign w_arst_n = rstn & ~por;

    reset_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_reset_sync (
        .clk         (clk),
        .arst_n      (w_arst_n),
        .rel_n       (w_rel),
        .rel_early_n (w_rel_early)
    );

    assign w_ch_next    = r_ch + 1'b1;
    // Software request only acts once the synchroniser has been passed
    assign w_sw_restart = sw_rst_req &&
                          (r_state == ST_STRETCH || r_state == ST_RELEASE ||
                           r_state == ST_RUN);

    // Sequencer: sync wait, stretch count, ordered channel release, run
    always_ff @(posedge clk or negedge w_arst_n) begin
        if (!w_arst_n) begin
            r_state <= ST_RESET;
            r_cnt   <= '0;
            r_gcnt  <= '0;
            r_ch    <= '0;
            r_rst   <= '1;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else if (w_sw_restart) begin
            r_state <= ST_STRETCH;
            r_cnt   <= '0;
            r_rst   <= '1;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                ST_RESET: begin
                    r_state <= ST_SYNC;
                    r_busy  <= 1'b1;
                end
                ST_SYNC: begin
                    // The early tap lets the stretch count start on the edge
                    // the chain output itself goes high
                    if (w_rel_early || w_rel) begin
                        r_state <= ST_STRETCH;
                        r_cnt   <= '0;
                    end
                end
                ST_STRETCH: begin
                    if (r_cnt == C_CNT_LAST) begin
                        r_rst[0] <= 1'b0;
                        r_gcnt   <= '0;
                        r_ch     <= '0;
                        if (NCH == 1) begin
                            r_state <= ST_RUN;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_RELEASE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (r_gcnt == C_GAP_LAST) begin
                        r_rst  <= r_rst & ~(C_CH_ONE << w_ch_next);
                        r_ch   <= w_ch_next;
                        r_gcnt <= '0;
                        if (w_ch_next == C_CH_LAST) begin
                            r_state <= ST_RUN;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_gcnt <= r_gcnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_RESET;
                    r_rst   <= '1;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rst   = r_rst;
    assign ready = r_ready;
    assign busy  = r_busy;

endmodule : reset_sequencer
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Scoreboard bench. Stimulus pushes hand-computed output
//               changes (cycle, rst, ready, busy); monitors pop and compare
//               whenever a DUT's outputs change.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    typedef struct {
        int         cyc;   // -1: cycle not checked
        logic [2:0] rst;
        logic       ready;
        logic       busy;
        int         tid;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn1 = 1'b0, por1 = 1'b0, sw1 = 1'b0;
    logic [2:0] rst1;
    logic       ready1, busy1;
    logic       rstn2 = 1'b0, por2 = 1'b0, sw2 = 1'b0;
    logic [0:0] rst2;
    logic       ready2, busy2;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   tid = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    logic [4:0] cur1, prev1;
    logic [2:0] cur2, prev2;

    reset_sequencer #(.NCH(3), .SYNC_STAGES(2), .STRETCH(16), .GAP(4)) u_dut1 (
        .clk(clk), .rstn(rstn1), .por(por1), .sw_rst_req(sw1),
        .rst(rst1), .ready(ready1), .busy(busy1)
    );

    reset_sequencer #(.NCH(1), .SYNC_STAGES(3), .STRETCH(1), .GAP(1)) u_dut2 (
        .clk(clk), .rstn(rstn2), .por(por2), .sw_rst_req(sw2),
        .rst(rst2), .ready(ready2), .busy(busy2)
    );

    always #5 clk = ~clk;

    // Posedge count; at a negedge, cyc is the number of the edge just passed
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push1(input int c, input logic [2:0] r, input logic rd, input logic b);
        q1.push_back('{c, r, rd, b, tid});
    endtask

    task automatic push2(input int c, input logic r, input logic rd, input logic b);
        q2.push_back('{c, {2'b00, r}, rd, b, tid});
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q1.size() != 0 || q2.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout_t%0d pending got=%0d/%0d want=0/0", tid, q1.size(), q2.size());
            q1.delete();
            q2.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor for the default-parameter instance
    initial forever begin
        @(negedge clk);
        cur1 = {rst1, ready1, busy1};
        if (cur1 !== prev1) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL dut1_unexpected cyc=%0d got=%b want=no_change", cyc, cur1);
            end else begin
                e1 = q1.pop_front();
                if ((e1.cyc >= 0 && e1.cyc != cyc) || cur1 !== {e1.rst, e1.ready, e1.busy}) begin
                    bad++;
                    $display("FAIL dut1_t%0d cyc got=%0d want=%0d out(rst,ready,busy) got=%b want=%b",
                             e1.tid, cyc, e1.cyc, cur1, {e1.rst, e1.ready, e1.busy});
                end
            end
            prev1 = cur1;
        end
    end

    // Monitor for the single-channel instance
    initial forever begin
        @(negedge clk);
        cur2 = {rst2, ready2, busy2};
        if (cur2 !== prev2) begin
            total++;
            if (q2.size() == 0) begin
                bad++;
                $display("FAIL dut2_unexpected cyc=%0d got=%b want=no_change", cyc, cur2);
            end else begin
                e2 = q2.pop_front();
                if ((e2.cyc >= 0 && e2.cyc != cyc) || cur2 !== {e2.rst[0], e2.ready, e2.busy}) begin
                    bad++;
                    $display("FAIL dut2_t%0d cyc got=%0d want=%0d out(rst,ready,busy) got=%b want=%b",
                             e2.tid, cyc, e2.cyc, cur2, {e2.rst[0], e2.ready, e2.busy});
                end
            end
            prev2 = cur2;
        end
    end

    initial begin
        int c;
        int d;

        // Reset state of both instances
        tid = 0;
        push1(-1, 3'b111, 1'b0, 1'b0);
        push2(-1, 1'b1, 1'b0, 1'b0);

        // 1: power-up release, default timing 18/22/26
        wait_until(5);
        tid = 1;
        rstn1 = 1'b1;
        c = cyc;
        push1(c + 1,  3'b111, 1'b0, 1'b1);
        push1(c + 18, 3'b110, 1'b0, 1'b1);
        push1(c + 22, 3'b100, 1'b0, 1'b1);
        push1(c + 26, 3'b000, 1'b1, 1'b0);
        drain(60);

        // 2: one-cycle software reset in RUN
        tid = 2;
        c = cyc;
        sw1 = 1'b1;
        push1(c + 1,  3'b111, 1'b0, 1'b1);
        push1(c + 17, 3'b110, 1'b0, 1'b1);
        push1(c + 21, 3'b100, 1'b0, 1'b1);
        push1(c + 25, 3'b000, 1'b1, 1'b0);
        @(negedge clk);
        sw1 = 1'b0;
        drain(60);

        // 3: software reset between rst[0] and rst[1] release
        tid = 3;
        c = cyc;
        sw1 = 1'b1;
        push1(c + 1,  3'b111, 1'b0, 1'b1);
        push1(c + 17, 3'b110, 1'b0, 1'b1);
        push1(c + 19, 3'b111, 1'b0, 1'b1);
        push1(c + 35, 3'b110, 1'b0, 1'b1);
        push1(c + 39, 3'b100, 1'b0, 1'b1);
        push1(c + 43, 3'b000, 1'b1, 1'b0);
        @(negedge clk);
        sw1 = 1'b0;
        wait_until(c + 18);
        sw1 = 1'b1;
        @(negedge clk);
        sw1 = 1'b0;
        drain(80);

        // 4: 3 ns por glitch in RUN, asserted and released between edges
        tid = 4;
        c = cyc;
        push1(c + 1,  3'b111, 1'b0, 1'b1);
        push1(c + 18, 3'b110, 1'b0, 1'b1);
        push1(c + 22, 3'b100, 1'b0, 1'b1);
        push1(c + 26, 3'b000, 1'b1, 1'b0);
        #1 por1 = 1'b1;
        #1;
        total++;
        if ({rst1, ready1, busy1} !== 5'b11100) begin
            bad++;
            $display("FAIL por_async out(rst,ready,busy) got=%b want=11100", {rst1, ready1, busy1});
        end
        #2 por1 = 1'b0;
        drain(60);

        // 5: rstn dropped in STRETCH at cnt=7, no carry-over after release
        tid = 5;
        c = cyc;
        push1(c + 1, 3'b111, 1'b0, 1'b0);
        #1 rstn1 = 1'b0;
        wait_until(c + 4);
        rstn1 = 1'b1;
        d = cyc;
        push1(d + 1,  3'b111, 1'b0, 1'b1);
        push1(d + 10, 3'b111, 1'b0, 1'b0);
        wait_until(d + 9);
        #1 rstn1 = 1'b0;
        wait_until(d + 12);
        rstn1 = 1'b1;
        c = cyc;
        push1(c + 1,  3'b111, 1'b0, 1'b1);
        push1(c + 18, 3'b110, 1'b0, 1'b1);
        push1(c + 22, 3'b100, 1'b0, 1'b1);
        push1(c + 26, 3'b000, 1'b1, 1'b0);
        drain(60);

        // 6: NCH=1, SYNC_STAGES=3, STRETCH=1, GAP=1
        tid = 6;
        rstn2 = 1'b1;
        c = cyc;
        push2(c + 1, 1'b1, 1'b0, 1'b1);
        push2(c + 4, 1'b0, 1'b1, 1'b0);
        drain(20);
        c = cyc;
        sw2 = 1'b1;
        push2(c + 1,  1'b1, 1'b0, 1'b1);
        push2(c + 11, 1'b0, 1'b1, 1'b0);
        wait_until(c + 10);
        sw2 = 1'b0;
        drain(20);

        // Nothing may remain expected
        total++;
        if (q1.size() != 0 || q2.size() != 0) begin
            bad++;
            $display("FAIL leftover got=%0d/%0d want=0/0", q1.size(), q2.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reset_sequencer
`default_nettype wire
